// File: rtl/count_event_monitor.sv
// Watches an upstream counter's value and queues WRAP / THRESH / LOAD events
// in a small FIFO, with sticky overflow tracking for events that did not fit.
module count_event_monitor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         cnt_in,
    input  logic                     mon_en,
    input  logic [WIDTH-1:0]         cfg_thresh,
    input  logic                     ovf_clr,
    input  logic                     evt_ready,
    output logic                     evt_valid,
    output logic [1:0]               evt_type,
    output logic [WIDTH-1:0]         evt_value,
    output logic                     ovf,
    output logic [7:0]               drop_cnt,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {
        EVT_NONE   = 2'b00,
        EVT_WRAP   = 2'b01,
        EVT_THRESH = 2'b10,
        EVT_LOAD   = 2'b11
    } evt_t;

    typedef struct packed {
        logic [1:0]       kind;
        logic [WIDTH-1:0] value;
    } entry_t;

    logic [WIDTH-1:0] prev_cnt;
    logic             primed;
    entry_t           mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    evt_t             det_type_c;
    entry_t           new_entry_c;
    entry_t           head_next_c;
    logic             push_c;
    logic             pop_c;
    logic             full_c;
    logic             push_ok_c;
    logic             drop_c;
    logic [LW-1:0]    level_next_c;
    logic [LW-1:0]    kept_c;
    logic [AW-1:0]    rd_next_c;

    // Classify the change; an increment that is neither a wrap nor a threshold hit is silent.
    always_comb begin
        det_type_c = EVT_NONE;
        if (primed && mon_en && (cnt_in != prev_cnt)) begin
            if (cnt_in == prev_cnt + WIDTH'(1)) begin
                if (&prev_cnt) begin
                    det_type_c = EVT_WRAP;
                end else if (cnt_in == cfg_thresh) begin
                    det_type_c = EVT_THRESH;
                end
            end else begin
                det_type_c = EVT_LOAD;
            end
        end
    end

    // FIFO bookkeeping and the next head entry, so the outputs come straight from flops.
    always_comb begin
        new_entry_c.kind  = det_type_c;
        new_entry_c.value = cnt_in;
        push_c       = (det_type_c != EVT_NONE);
        pop_c        = evt_valid && evt_ready;
        full_c       = (fifo_level == LW'(DEPTH));
        push_ok_c    = push_c && (!full_c || pop_c);
        drop_c       = push_c && full_c && !pop_c;
        level_next_c = fifo_level + LW'(push_ok_c) - LW'(pop_c);
        kept_c       = fifo_level - LW'(pop_c);
        rd_next_c    = rd_ptr + AW'(pop_c);
        head_next_c  = '0;
        if (kept_c == LW'(0)) begin
            if (push_ok_c) begin
                head_next_c = new_entry_c;
            end
        end else begin
            head_next_c = mem[rd_next_c];
        end
    end

    // prev_cnt tracks the counter unconditionally so re-enabling never sees a stale value.
    always_ff @(posedge clk) begin
        prev_cnt <= cnt_in;
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok_c) begin
            mem[wr_ptr] <= new_entry_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            primed     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            evt_valid  <= 1'b0;
            evt_type   <= '0;
            evt_value  <= '0;
            ovf        <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            primed     <= 1'b1;
            wr_ptr     <= wr_ptr + AW'(push_ok_c);
            rd_ptr     <= rd_next_c;
            fifo_level <= level_next_c;
            evt_valid  <= (level_next_c != LW'(0));
            evt_type   <= head_next_c.kind;
            evt_value  <= head_next_c.value;
            // A drop on the same edge as a clear restarts the count at one.
            if (drop_c) begin
                ovf <= 1'b1;
                if (ovf_clr) begin
                    drop_cnt <= 8'd1;
                end else if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end else if (ovf_clr) begin
                ovf      <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_count_event_monitor.sv
// Directed bench for count_event_monitor: each task drives one scenario and
// checks outputs against hand-computed values.
module tb_count_event_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cnt_in;
    logic       mon_en;
    logic [7:0] cfg_thresh;
    logic       ovf_clr;
    logic       evt_ready;
    logic       evt_valid;
    logic [1:0] evt_type;
    logic [7:0] evt_value;
    logic       ovf;
    logic [7:0] drop_cnt;
    logic [2:0] fifo_level;

    int n_vec = 0;
    int n_err = 0;

    count_event_monitor #(.WIDTH(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_in     (cnt_in),
        .mon_en     (mon_en),
        .cfg_thresh (cfg_thresh),
        .ovf_clr    (ovf_clr),
        .evt_ready  (evt_ready),
        .evt_valid  (evt_valid),
        .evt_type   (evt_type),
        .evt_value  (evt_value),
        .ovf        (ovf),
        .drop_cnt   (drop_cnt),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, then prime with value v; no event comes from the priming edge.
    task automatic do_reset(input logic [7:0] v);
        rst = 1'b1; cnt_in = v; ovf_clr = 1'b0; evt_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; cnt_in = 8'h00; mon_en = 1'b1; cfg_thresh = 8'h80;
        ovf_clr = 1'b0; evt_ready = 1'b0;
        tick(); tick();
        n_vec++;
        if ({evt_valid, fifo_level, ovf, drop_cnt} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_state: got v=%b lvl=%0d ovf=%b drop=%0d, want all 0",
                     evt_valid, fifo_level, ovf, drop_cnt);
        end
        n_vec++;
        if ({evt_type, evt_value} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_head: got type=%b value=%h, want 0/00", evt_type, evt_value);
        end
    endtask

    task automatic test_wrap();
        mon_en = 1'b1; cfg_thresh = 8'h80;
        do_reset(8'hFE);
        evt_ready = 1'b1;
        cnt_in = 8'hFF; tick();
        n_vec++;
        if (evt_valid !== 1'b0) begin
            n_err++; $display("FAIL wrap_pre: evt_valid=%b, want 0", evt_valid);
        end
        cnt_in = 8'h00; tick();
        n_vec++;
        if ({evt_valid, evt_type, evt_value} !== {1'b1, 2'b01, 8'h00}) begin
            n_err++;
            $display("FAIL wrap_event: got v=%b type=%b value=%h, want 1/01/00",
                     evt_valid, evt_type, evt_value);
        end
        tick();
        n_vec++;
        if ({evt_valid, fifo_level} !== 4'd0) begin
            n_err++;
            $display("FAIL wrap_one_cycle: got v=%b lvl=%0d, want 0/0", evt_valid, fifo_level);
        end
    endtask

    task automatic test_wrap_thresh_zero();
        mon_en = 1'b1; cfg_thresh = 8'h00;
        do_reset(8'hFF);
        cnt_in = 8'h00; tick();
        n_vec++;
        if ({fifo_level, evt_type} !== {3'd1, 2'b01}) begin
            n_err++;
            $display("FAIL wrap_priority: got lvl=%0d type=%b, want 1/01", fifo_level, evt_type);
        end
        n_vec++;
        if (ovf !== 1'b0) begin
            n_err++; $display("FAIL wrap_priority_ovf: ovf=%b, want 0", ovf);
        end
    endtask

    task automatic test_thresh();
        mon_en = 1'b1; cfg_thresh = 8'h80;
        do_reset(8'h7E);
        cnt_in = 8'h7F; tick();
        n_vec++;
        if (evt_valid !== 1'b0) begin
            n_err++; $display("FAIL thresh_pre: evt_valid=%b, want 0", evt_valid);
        end
        cnt_in = 8'h80; tick();
        cnt_in = 8'h81; tick();
        n_vec++;
        if ({evt_valid, evt_type, evt_value, fifo_level} !== {1'b1, 2'b10, 8'h80, 3'd1}) begin
            n_err++;
            $display("FAIL thresh_event: got v=%b type=%b value=%h lvl=%0d, want 1/10/80/1",
                     evt_valid, evt_type, evt_value, fifo_level);
        end
        evt_ready = 1'b1; tick();
        evt_ready = 1'b0; cnt_in = 8'h10; tick();
        evt_ready = 1'b1; tick();
        evt_ready = 1'b0; cnt_in = 8'h80; tick();
        n_vec++;
        if ({fifo_level, evt_type, evt_value} !== {3'd1, 2'b11, 8'h80}) begin
            n_err++;
            $display("FAIL thresh_load: got lvl=%0d type=%b value=%h, want 1/11/80",
                     fifo_level, evt_type, evt_value);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_v;
        mon_en = 1'b1; cfg_thresh = 8'h80;
        do_reset(8'h00);
        for (int i = 1; i <= 6; i++) begin
            cnt_in = 8'(i * 16); tick();
        end
        n_vec++;
        if ({fifo_level, ovf, drop_cnt} !== {3'd4, 1'b1, 8'd2}) begin
            n_err++;
            $display("FAIL ovf_state: got lvl=%0d ovf=%b drop=%0d, want 4/1/2",
                     fifo_level, ovf, drop_cnt);
        end
        evt_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            exp_v = 8'(i * 16);
            n_vec++;
            if ({evt_valid, evt_type, evt_value} !== {1'b1, 2'b11, exp_v}) begin
                n_err++;
                $display("FAIL ovf_drain%0d: got v=%b type=%b value=%h, want 1/11/%h",
                         i, evt_valid, evt_type, evt_value, exp_v);
            end
            tick();
        end
        n_vec++;
        if ({evt_valid, fifo_level} !== 4'd0) begin
            n_err++;
            $display("FAIL ovf_empty: got v=%b lvl=%0d, want 0/0", evt_valid, fifo_level);
        end
        tick();
        n_vec++;
        if ({evt_valid, fifo_level} !== 4'd0) begin
            n_err++;
            $display("FAIL ready_on_empty: got v=%b lvl=%0d, want 0/0", evt_valid, fifo_level);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q [4];
        exp_q[0] = 8'h22; exp_q[1] = 8'h33; exp_q[2] = 8'h44; exp_q[3] = 8'h55;
        evt_ready = 1'b0;
        cnt_in = 8'h11; tick();
        cnt_in = 8'h22; tick();
        cnt_in = 8'h33; tick();
        cnt_in = 8'h44; tick();
        evt_ready = 1'b1; cnt_in = 8'h55; tick();
        n_vec++;
        if ({fifo_level, drop_cnt} !== {3'd4, 8'd2}) begin
            n_err++;
            $display("FAIL full_push_pop: got lvl=%0d drop=%0d, want 4/2", fifo_level, drop_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({evt_valid, evt_value} !== {1'b1, exp_q[i]}) begin
                n_err++;
                $display("FAIL full_order%0d: got v=%b value=%h, want 1/%h",
                         i, evt_valid, evt_value, exp_q[i]);
            end
            tick();
        end
    endtask

    task automatic test_clear_collision();
        evt_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cnt_in = 8'(2 * i + 1); tick();
        end
        n_vec++;
        if ({ovf, drop_cnt} !== {1'b1, 8'd5}) begin
            n_err++;
            $display("FAIL clr_setup: got ovf=%b drop=%0d, want 1/5", ovf, drop_cnt);
        end
        ovf_clr = 1'b1; cnt_in = 8'h0F; tick();
        n_vec++;
        if ({ovf, drop_cnt} !== {1'b1, 8'd1}) begin
            n_err++;
            $display("FAIL clr_collision: got ovf=%b drop=%0d, want 1/1", ovf, drop_cnt);
        end
        tick();
        ovf_clr = 1'b0;
        n_vec++;
        if ({ovf, drop_cnt} !== {1'b0, 8'd0}) begin
            n_err++;
            $display("FAIL clr_plain: got ovf=%b drop=%0d, want 0/0", ovf, drop_cnt);
        end
        for (int i = 0; i < 260; i++) begin
            cnt_in = i[0] ? 8'hA5 : 8'h5A; tick();
        end
        n_vec++;
        if ({ovf, drop_cnt, fifo_level} !== {1'b1, 8'd255, 3'd4}) begin
            n_err++;
            $display("FAIL drop_saturate: got ovf=%b drop=%0d lvl=%0d, want 1/255/4",
                     ovf, drop_cnt, fifo_level);
        end
    endtask

    task automatic test_mon_en();
        mon_en = 1'b1; cfg_thresh = 8'h80;
        do_reset(8'h00);
        cnt_in = 8'h10; tick();
        mon_en = 1'b0;
        cnt_in = 8'h20; tick();
        cnt_in = 8'h30; tick();
        n_vec++;
        if ({evt_valid, fifo_level, evt_value} !== {1'b1, 3'd1, 8'h10}) begin
            n_err++;
            $display("FAIL mon_off_hold: got v=%b lvl=%0d value=%h, want 1/1/10",
                     evt_valid, fifo_level, evt_value);
        end
        mon_en = 1'b1; tick();
        n_vec++;
        if (fifo_level !== 3'd1) begin
            n_err++; $display("FAIL mon_reenable: lvl=%0d, want 1", fifo_level);
        end
        evt_ready = 1'b1; tick();
        n_vec++;
        if ({evt_valid, fifo_level} !== 4'd0) begin
            n_err++;
            $display("FAIL mon_drain: got v=%b lvl=%0d, want 0/0", evt_valid, fifo_level);
        end
    endtask

    task automatic test_reset_midstream();
        mon_en = 1'b1; cfg_thresh = 8'h80;
        do_reset(8'h00);
        cnt_in = 8'h10; tick();
        cnt_in = 8'h20; tick();
        cnt_in = 8'h30; tick();
        n_vec++;
        if (fifo_level !== 3'd3) begin
            n_err++; $display("FAIL mid_setup: lvl=%0d, want 3", fifo_level);
        end
        rst = 1'b1; evt_ready = 1'b1; cnt_in = 8'h42; tick();
        n_vec++;
        if ({evt_valid, fifo_level, evt_type, evt_value} !== 14'd0) begin
            n_err++;
            $display("FAIL mid_reset: got v=%b lvl=%0d type=%b value=%h, want all 0",
                     evt_valid, fifo_level, evt_type, evt_value);
        end
        rst = 1'b0; tick();
        n_vec++;
        if ({evt_valid, fifo_level} !== 4'd0) begin
            n_err++;
            $display("FAIL mid_prime: got v=%b lvl=%0d, want 0/0", evt_valid, fifo_level);
        end
        evt_ready = 1'b0; cnt_in = 8'h43; tick();
        n_vec++;
        if (fifo_level !== 3'd0) begin
            n_err++; $display("FAIL mid_incr: lvl=%0d, want 0", fifo_level);
        end
        cfg_thresh = 8'h44; cnt_in = 8'h44; tick();
        n_vec++;
        if ({evt_valid, evt_type, evt_value} !== {1'b1, 2'b10, 8'h44}) begin
            n_err++;
            $display("FAIL mid_thresh: got v=%b type=%b value=%h, want 1/10/44",
                     evt_valid, evt_type, evt_value);
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_wrap_thresh_zero();
        test_thresh();
        test_overflow();
        test_back_to_back();
        test_clear_collision();
        test_mon_en();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
